// File: rtl/difftest_step_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_step_scheduler_if
//  Purpose  : Step-issue handshake bundle between the step scheduler and the
//             deferred-result / step-forwarding stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface difftest_step_scheduler_if #(
  parameter int ACC_W = 16,
  parameter int ID_W  = 2
);
  logic             issue_valid;
  logic             issue_ready;
  logic [ACC_W-1:0] issue_step;
  logic [ID_W-1:0]  issue_id;

  modport master (
    output issue_valid,
    output issue_step,
    output issue_id,
    input  issue_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_step,
    input  issue_id,
    output issue_ready
  );
endinterface
`default_nettype wire

// File: rtl/difftest_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_step_scheduler
//  Purpose  : Accumulates per-requester step reports and issues them
//             round-robin, in batches of at most BATCH_MAX, over a
//             valid/ready stream. Freezes once a nonzero result arrives.
//  Option   : STEP_SCHED_FLUSH_ON_HALT_EN - drain all accumulated steps
//             (FLUSH state) before halting instead of discarding them.
//  Revision : 1.0 - initial release
// ============================================================================
module difftest_step_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int STEP_W    = 8,
  parameter int ACC_W     = 16,
  parameter int BATCH_MAX = 64
) (
  input  wire logic                      clock,
  input  wire logic                      reset,
  input  wire logic [NUM_REQ*STEP_W-1:0] req_step,
  input  wire logic [7:0]                result_in,
  difftest_step_scheduler_if.master      issue,
  output logic                           halted,
  output logic                           overflow
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = ((ACC_W > STEP_W) ? ACC_W : STEP_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX   = SUM_W'({ACC_W{1'b1}});
  localparam logic [ACC_W-1:0] BATCH_LIM = ACC_W'(BATCH_MAX);
  localparam logic [ID_W:0]    NREQ_W    = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

`ifdef STEP_SCHED_FLUSH_ON_HALT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, FLUSH = 2'd2, HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HALT = 2'd3} state_t;
`endif

  state_t           state, state_next;
  logic [ACC_W-1:0] acc      [NUM_REQ];
  logic [ACC_W-1:0] acc_next [NUM_REQ];
  logic [ID_W-1:0]  rr, sel, rr_next;
  logic [ID_W:0]    idx;
  logic [ACC_W-1:0] dec;
  logic [SUM_W-1:0] sum;
  logic             any_pending, sat_any, load, handshake, res_now, res_seen, stop_req;

  assign res_now   = (result_in != 8'd0);
  // A result seen at any earlier point stays pending until the FSM acts on it.
  assign stop_req  = res_now | res_seen;
  assign handshake = issue.issue_valid & issue.issue_ready;
  assign issue.issue_valid = (state == ISSUE);
  assign halted            = (state == HALT);
  assign rr_next = (sel == LAST_ID) ? '0 : sel + ID_W'(1);

  // Round-robin pick: first requester from rr upward (wrapping) with work.
  always_comb begin
    sel         = '0;
    any_pending = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr} + (ID_W+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!any_pending && acc[idx[ID_W-1:0]] != '0) begin
        sel         = idx[ID_W-1:0];
        any_pending = 1'b1;
      end
    end
  end

  // Accumulator update: add new reports, retire accepted batch, saturate.
  // The accepted batch never exceeds the accumulator it came from, so the
  // subtraction cannot underflow.
  always_comb begin
    sat_any = 1'b0;
    dec     = '0;
    sum     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec = (handshake && issue.issue_id == ID_W'(i)) ? issue.issue_step : '0;
      sum = SUM_W'(acc[i]) - SUM_W'(dec) + SUM_W'(req_step[i*STEP_W +: STEP_W]);
      if (state == HALT) begin
        acc_next[i] = acc[i];
      end else if (sum > ACC_MAX) begin
        acc_next[i] = '1;
        sat_any     = 1'b1;
      end else begin
        acc_next[i] = sum[ACC_W-1:0];
      end
    end
  end

  // Next-state logic; load marks the cycle a new batch is captured.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (stop_req) begin
`ifdef STEP_SCHED_FLUSH_ON_HALT_EN
          state_next = FLUSH;
`else
          state_next = HALT;
`endif
        end else if (any_pending) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          if (stop_req) begin
`ifdef STEP_SCHED_FLUSH_ON_HALT_EN
            state_next = FLUSH;
`else
            state_next = HALT;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
`ifdef STEP_SCHED_FLUSH_ON_HALT_EN
      FLUSH: begin
        if (any_pending) begin
          load       = 1'b1;
          state_next = ISSUE;
        end else begin
          state_next = HALT;
        end
      end
`endif
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Accumulators, round-robin pointer, issue payload and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) acc[i] <= '0;
      rr               <= '0;
      issue.issue_step <= '0;
      issue.issue_id   <= '0;
      res_seen         <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      acc <= acc_next;
      if (sat_any) overflow <= 1'b1;
      if (res_now) res_seen <= 1'b1;
      if (load) begin
        issue.issue_step <= (acc[sel] > BATCH_LIM) ? BATCH_LIM : acc[sel];
        issue.issue_id   <= sel;
        rr               <= rr_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_difftest_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_difftest_step_scheduler
//  Purpose  : Self-checking bench: directed tables, hand-written corner
//             sequences and randomized traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_difftest_step_scheduler;

`ifdef STEP_SCHED_FLUSH_ON_HALT_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif
  localparam int MAXV  = 65535;
  localparam int BATCH = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] req_step = '0;
  logic [7:0]  result_in = '0;
  logic        halted, overflow;

  difftest_step_scheduler_if #(.ACC_W(16), .ID_W(2)) bus ();

  difftest_step_scheduler #(.NUM_REQ(4), .STEP_W(8), .ACC_W(16), .BATCH_MAX(BATCH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_step  (req_step),
    .result_in (result_in),
    .issue     (bus),
    .halted    (halted),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_q[$];   // accepted issues, encoded id*65536 + step

  // Reference model: pending counts per requester plus the issue in flight.
  int m_acc[4];
  int m_rr, m_step, m_id;
  bit m_valid, m_halt, m_seen, m_flush, m_ovf;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    m_rr = 0; m_step = 0; m_id = 0;
    m_valid = 0; m_halt = 0; m_seen = 0; m_flush = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge(input logic [31:0] req, input logic [7:0] res, input bit rdy);
    bit hs, stop, any;
    int s, v, pick_step;
    if (m_halt) return;
    hs   = m_valid && rdy;
    stop = (res != 0) || m_seen;
    any  = 0; s = 0;
    for (int k = 0; k < 4; k++)
      if (!any && m_acc[(m_rr + k) % 4] > 0) begin any = 1; s = (m_rr + k) % 4; end
    pick_step = (any && m_acc[s] > BATCH) ? BATCH : m_acc[s];
    for (int i = 0; i < 4; i++) begin
      v = m_acc[i] + int'(req[i*8 +: 8]) - ((hs && m_id == i) ? m_step : 0);
      if (v > MAXV) begin v = MAXV; m_ovf = 1; end
      m_acc[i] = v;
    end
    if (m_valid) begin
      if (hs) begin
        m_valid = 0;
        if (stop) begin if (FLUSH_ON) m_flush = 1; else m_halt = 1; end
      end
    end else if (m_flush) begin
      if (any) begin m_valid = 1; m_step = pick_step; m_id = s; m_rr = (s + 1) % 4; end
      else m_halt = 1;
    end else if (stop) begin
      if (FLUSH_ON) m_flush = 1; else m_halt = 1;
    end else if (any) begin
      m_valid = 1; m_step = pick_step; m_id = s; m_rr = (s + 1) % 4;
    end
    if (res != 0) m_seen = 1;
  endfunction

  task automatic chk_model();
    chk("model_valid", int'(bus.issue_valid), int'(m_valid));
    chk("model_halted", int'(halted), int'(m_halt));
    chk("model_overflow", int'(overflow), int'(m_ovf));
    if (m_valid) begin
      chk("model_step", int'(bus.issue_step), m_step);
      chk("model_id", int'(bus.issue_id), m_id);
    end
  endtask

  // One clock cycle: drive inputs, log any handshake, advance model, compare.
  task automatic cyc(input logic [31:0] req, input logic [7:0] res, input logic rdy);
    req_step = req; result_in = res; bus.issue_ready = rdy;
    #1;
    if (bus.issue_valid && rdy) hs_q.push_back(int'(bus.issue_id) * 65536 + int'(bus.issue_step));
    @(posedge clock);
    model_edge(req, res, rdy);
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; req_step = '0; result_in = '0; bus.issue_ready = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    hs_q.delete();
  endtask

  typedef struct {
    logic [31:0] req;
    logic [7:0]  res;
    logic        rdy;
    logic        ev;
    int          es;
    int          eid;
    logic        eh;
  } vec_t;

  function automatic vec_t mk(logic [31:0] req, logic rdy, logic ev, int es, int eid);
    vec_t v;
    v.req = req; v.res = 8'd0; v.rdy = rdy; v.ev = ev; v.es = es; v.eid = eid; v.eh = 1'b0;
    return v;
  endfunction

  task automatic run_table(input string tag, input vec_t t[$]);
    foreach (t[n]) begin
      cyc(t[n].req, t[n].res, t[n].rdy);
      chk({tag, "_valid"}, int'(bus.issue_valid), int'(t[n].ev));
      chk({tag, "_halted"}, int'(halted), int'(t[n].eh));
      if (t[n].ev) begin
        chk({tag, "_step"}, int'(bus.issue_step), t[n].es);
        chk({tag, "_id"}, int'(bus.issue_id), t[n].eid);
      end
    end
  endtask

  task automatic chk_hs(input string name, input int exp[$]);
    chk({name, "_count"}, hs_q.size(), exp.size());
    foreach (exp[n]) if (n < hs_q.size()) chk({name, "_issue"}, hs_q[n], exp[n]);
  endtask

  vec_t single_t[$];
  vec_t fair_t[$];

  initial begin
    int exp_q[$];
    logic [31:0] r;

    single_t = '{mk(32'h0000_0005, 1, 0, 0, 0), mk(0, 1, 1, 5, 0),
                 mk(0, 1, 0, 0, 0), mk(0, 1, 0, 0, 0)};
    fair_t   = '{mk(32'h0303_0303, 1, 0, 0, 0), mk(0, 1, 1, 3, 0), mk(0, 1, 0, 0, 0),
                 mk(0, 1, 1, 3, 1), mk(0, 1, 0, 0, 0), mk(0, 1, 1, 3, 2),
                 mk(0, 1, 0, 0, 0), mk(0, 1, 1, 3, 3), mk(0, 1, 0, 0, 0),
                 mk(0, 1, 0, 0, 0)};

    // Reset state
    do_reset();
    chk("rst_valid", int'(bus.issue_valid), 0);
    chk("rst_step", int'(bus.issue_step), 0);
    chk("rst_id", int'(bus.issue_id), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_overflow", int'(overflow), 0);

    run_table("single", single_t);
    do_reset();
    run_table("fair", fair_t);

    // Batching: 150 steps on requester 2 -> 64, 64, 22
    do_reset();
    cyc(32'h0096_0000, 0, 1);
    repeat (12) cyc(0, 0, 1);
    exp_q = '{2*65536 + 64, 2*65536 + 64, 2*65536 + 22};
    chk_hs("batch", exp_q);

    // Backpressure: payload holds while stalled, stalled steps come next
    do_reset();
    cyc(32'h1, 0, 0);
    repeat (10) begin
      cyc(32'h1, 0, 0);
      chk("stall_valid", int'(bus.issue_valid), 1);
      chk("stall_step", int'(bus.issue_step), 1);
      chk("stall_id", int'(bus.issue_id), 0);
    end
    repeat (5) cyc(0, 0, 1);
    exp_q = '{1, 10};
    chk_hs("stall", exp_q);

    // Result pulse with requester 1 holding 7 steps
    do_reset();
    cyc(32'h0000_0700, 0, 0);
    cyc(0, 8'h01, 1);
    repeat (8) cyc(0, 0, 1);
    if (FLUSH_ON) exp_q = '{65536 + 7};
    else          exp_q = '{};
    chk_hs("halt", exp_q);
    chk("halt_halted", int'(halted), 1);
    repeat (3) cyc(32'h0101_0101, 0, 1);
    chk("halt_frozen_valid", int'(bus.issue_valid), 0);
    chk("halt_frozen_halted", int'(halted), 1);

    // Saturation: 257*255 = 65535 fits exactly, one more report saturates
    do_reset();
    repeat (257) cyc(32'hFF, 0, 0);
    chk("sat_edge_overflow", int'(overflow), 0);
    cyc(32'hFF, 0, 0);
    chk("sat_overflow", int'(overflow), 1);
    repeat (3) cyc(0, 0, 1);
    chk("sat_sticky", int'(overflow), 1);
    do_reset();
    chk("sat_cleared", int'(overflow), 0);

    // Reset while an issue is pending drops it without a handshake
    cyc(32'h1, 0, 0);
    cyc(0, 0, 0);
    chk("midrst_pending", int'(bus.issue_valid), 1);
    do_reset();
    chk("midrst_valid", int'(bus.issue_valid), 0);
    repeat (3) cyc(0, 0, 1);
    chk("midrst_idle", int'(bus.issue_valid), 0);

    // Randomized traffic, then a late result pulse
    do_reset();
    for (int c = 0; c < 500; c++) begin
      r = '0;
      if (c < 420)
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 9) >= 7) r[i*8 +: 8] = 8'($urandom_range(0, 255));
      cyc(r, (c == 430) ? 8'h05 : 8'h00, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
